// File: rtl/otter_intrpt_ctrl_if.sv
// Interrupt controller bus: irq lines and CSR/core
// signals in, take strobe, cause and status out.
interface otter_intrpt_ctrl_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CAUSE_W = 2
);
  logic [NUM_SRC-1:0] irq_in;
  logic               csr_mie;
  logic [31:0]        csr_mtvec;
  logic               instr_boundary;
  logic               intrpt_taken;
  logic [CAUSE_W-1:0] intrpt_cause;
  logic [31:0]        trap_pc;
  logic [NUM_SRC-1:0] irq_pending;
  logic [NUM_SRC-1:0] irq_overrun;

  modport master (
    output irq_in, csr_mie, csr_mtvec,
    output instr_boundary,
    input  intrpt_taken, intrpt_cause,
    input  trap_pc, irq_pending, irq_overrun
  );

  modport slave (
    input  irq_in, csr_mie, csr_mtvec,
    input  instr_boundary,
    output intrpt_taken, intrpt_cause,
    output trap_pc, irq_pending, irq_overrun
  );
endinterface

// File: rtl/otter_intrpt_ctrl.sv
// Synchronises and edge-latches external irqs and
// raises a one-cycle take at instruction boundaries.
module otter_intrpt_ctrl #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLDOFF_CYCLES = 2,
  parameter int unsigned CAUSE_W        =
    (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input logic                clk,
  input logic                rst,
  otter_intrpt_ctrl_if.slave bus
);
  localparam int unsigned CNT_W =
    (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int unsigned HOLD_INIT =
    (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

  typedef enum logic {IDLE, HOLD} state_e;
  typedef logic [NUM_SRC-1:0] vec_t;

  vec_t               sync_q [SYNC_STAGES];
  vec_t               sync_d [SYNC_STAGES];
  vec_t               prev_q, prev_d;
  vec_t               pend_q, pend_d;
  vec_t               ovr_q, ovr_d;
  vec_t               rise, clr;
  logic [CAUSE_W-1:0] cause_q, cause_d, sel;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic               take;

  always_comb begin
    sync_d[0] = bus.irq_in;
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // fixed priority: lowest index wins
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pend_q[i]) sel = CAUSE_W'(i);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    take    = 1'b0;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        take = bus.csr_mie & bus.instr_boundary
             & (|pend_q);
        if (take) begin
          clr     = vec_t'(1) << sel;
          cause_d = sel;
          if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLD_INIT);
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // a new edge on the bit being cleared keeps it pending
  always_comb begin
    pend_d = (pend_q & ~clr) | rise;
    ovr_d  = ovr_q | (rise & pend_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_d[i];
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign bus.intrpt_taken = take;
  assign bus.intrpt_cause = cause_q;
  assign bus.irq_pending  = pend_q;
  assign bus.irq_overrun  = ovr_q;
  assign bus.trap_pc      = bus.csr_mtvec & 32'hFFFF_FFFC;
endmodule
